multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle ARM datapath (fetch, decode, ALU, memory, writeback).

---
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multicycle ARM datapath
//
// Sequences fetch/decode/ALU/memory/writeback, owns the NZCV flags register,
// latches the condition-code result once per instruction at the end of DECODE
// and drives every datapath select and write enable combinationally from state.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   stall           freeze state/counter/flags, force write enables low
//   Op, Funct, Rd,  instruction fields (instr[27:26], [25:20], [15:12], [31:28])
//   Cond
//   ALUFlags        NZCV produced by the ALU this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegSrc   datapath controls
//   Flags           current NZCV register
//   state           FSM state (debug)
module multicycle_ctrl #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait;
  logic [3:0]    r_flags;
  logic          r_condex;

  logic [3:0] w_cmd;
  logic       w_cond_met;
  logic       w_flag_wr;
  logic       w_cv_wr;
  logic       w_fetch;
  logic       w_irw;
  logic       w_memw;
  logic       w_regw;
  logic       w_br;
  logic       w_en;

  assign w_cmd = Funct[4:1];

  // Condition evaluated against the flags as they stand during DECODE.
  always_comb begin
    w_cond_met = 1'b0;
    case (Cond)
      4'b0000: w_cond_met = r_flags[2];
      4'b0001: w_cond_met = ~r_flags[2];
      4'b0010: w_cond_met = r_flags[1];
      4'b0011: w_cond_met = ~r_flags[1];
      4'b0100: w_cond_met = r_flags[3];
      4'b0101: w_cond_met = ~r_flags[3];
      4'b0110: w_cond_met = r_flags[0];
      4'b0111: w_cond_met = ~r_flags[0];
      4'b1000: w_cond_met = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_met = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_met = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_met = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_met = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_met = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_met = 1'b1;
      default: w_cond_met = 1'b0;
    endcase
  end

  assign w_flag_wr = ((r_state == S_EXECR) || (r_state == S_EXECI)) && r_condex && Funct[0];
  // Logical ops leave carry/overflow untouched.
  assign w_cv_wr   = (w_cmd == CMD_ADD) || (w_cmd == CMD_SUB) || (w_cmd == CMD_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_wait   <= '0;
      r_flags  <= 4'b0000;
      r_condex <= 1'b0;
    end else if (!stall) begin
      r_state <= w_next;
      if (r_state == S_MEMRD && r_wait != WAIT_LAST) begin
        r_wait <= r_wait + CW'(1);
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_DECODE) begin
        r_condex <= w_cond_met;
      end
      if (w_flag_wr) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (w_cv_wr) begin
          r_flags[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_fetch    = 1'b0;
    w_irw      = 1'b0;
    w_memw     = 1'b0;
    w_regw     = 1'b0;
    w_br       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_next    = S_DECODE;
        w_fetch   = 1'b1;
        w_irw     = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        w_next = (r_wait == WAIT_LAST) ? S_MEMWB : S_MEMRD;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        w_next  = S_ALUWB;
        ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        case (w_cmd)
          CMD_SUB, CMD_CMP: ALUControl = 2'b01;
          CMD_AND:          ALUControl = 2'b10;
          CMD_ORR:          ALUControl = 2'b11;
          default:          ALUControl = 2'b00;
        endcase
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        w_regw    = (w_cmd != CMD_CMP);
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_br      = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are killed while frozen or held in reset; selects stay as decoded.
  assign w_en     = ~stall & ~reset;
  assign PCWrite  = w_en & (w_fetch | (r_condex & (w_br | (w_regw & (Rd == 4'd15)))));
  assign IRWrite  = w_en & w_irw;
  assign MemWrite = w_en & w_memw & r_condex;
  assign RegWrite = w_en & w_regw & r_condex & (Rd != 4'd15);
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign Flags    = r_flags;
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic reset, stall;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, state;

  multicycle_ctrl #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .Op(Op), .Funct(Funct), .Rd(Rd),
    .Cond(Cond), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, memw, irw, regw;
    logic [1:0] rs, a, b, aluc, imm, rsrc;
    logic [3:0] fl;
  } obs_t;

  obs_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] m_flags = 4'b0000;

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.pcw = PCWrite; o.adr = AdrSrc; o.memw = MemWrite;
    o.irw = IRWrite; o.regw = RegWrite; o.rs = ResultSrc; o.a = ALUSrcA;
    o.b = ALUSrcB; o.aluc = ALUControl; o.imm = ImmSrc; o.rsrc = RegSrc;
    o.fl = Flags;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;        1: return !z;
      2: return cy;       3: return !cy;
      4: return n;        5: return !n;
      6: return v;        7: return !v;
      8: return cy && !z; 9: return !cy || z;
      10: return n == v;  11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic obs_t exp_cycle(input int st, input logic c, input logic [1:0] op,
                                     input logic [5:0] f, input logic [3:0] rd);
    obs_t e = '0;
    logic wr;
    e.st = st[3:0];
    e.imm = op;
    e.rsrc = {op == 2'd1, op == 2'd2};
    case (st)
      0: begin e.pcw = 1; e.irw = 1; e.rs = 2; e.a = 1; e.b = 2; end
      1: begin e.rs = 2; e.a = 1; e.b = 2; end
      2: e.b = 1;
      3: e.adr = 1;
      4: begin e.rs = 1; e.regw = c && rd != 15; e.pcw = c && rd == 15; end
      5: begin e.adr = 1; e.memw = c; end
      6: begin e.b = 0; e.aluc = alu_of(f[4:1]); end
      7: begin e.b = 1; e.aluc = alu_of(f[4:1]); end
      8: begin
        wr = (f[4:1] != 4'b1010);
        e.regw = c && wr && rd != 15;
        e.pcw = c && wr && rd == 15;
      end
      9: begin e.rs = 2; e.b = 1; e.pcw = c; end
      default: ;
    endcase
    return e;
  endfunction

  // Plans one instruction from the architectural rules, queues the expected
  // per-cycle outputs, then drives it. Caller leaves the DUT in FETCH just after an edge.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input logic [3:0] cond, input logic [3:0] af,
                           input int stall_at, input int stall_len);
    int path[$];
    bit sseq[$];
    logic c;
    logic [3:0] fl;
    obs_t e;
    path = '{0, 1};
    case (op)
      2'd0: begin path.push_back(f[5] ? 7 : 6); path.push_back(8); end
      2'd1: begin
        path.push_back(2);
        if (f[0]) begin
          for (int k = 0; k < MW; k++) path.push_back(3);
          path.push_back(4);
        end else path.push_back(5);
      end
      2'd2: path.push_back(9);
      default: ;
    endcase
    c = cond_ok(cond, m_flags);
    fl = m_flags;
    for (int i = 0; i < path.size(); i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          e = exp_cycle(path[i], c, op, f, rd);
          e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0; e.fl = fl;
          exp_q.push_back(e);
          sseq.push_back(1'b1);
        end
      end
      e = exp_cycle(path[i], c, op, f, rd);
      e.fl = fl;
      exp_q.push_back(e);
      sseq.push_back(1'b0);
      if ((path[i] == 6 || path[i] == 7) && c && f[0]) begin
        fl[3:2] = af[3:2];
        if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) fl[1:0] = af[1:0];
      end
    end
    m_flags = fl;
    Op = op; Funct = f; Rd = rd; Cond = cond; ALUFlags = af;
    for (int k = 0; k < sseq.size(); k++) begin
      stall = sseq[k];
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, g;
      e = exp_q.pop_front();
      g = observe();
      n_chk++;
      if (g === e) n_pass++;
      else $display("FAIL cycle_outputs got=%h want=%h (st=%0d want st=%0d) t=%0t",
                    g, e, g.st, e.st, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; Op = 0; Funct = 0; Rd = 0; Cond = 4'hE; ALUFlags = 0;
    #3;
    chk("reset_state", 32'(state), 0);
    chk("reset_flags", 32'(Flags), 0);
    chk("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(2'd0, 6'b001000, 4'd1, 4'hE, 4'h0, -1, 0);   // ADD
    run_instr(2'd0, 6'b000101, 4'd2, 4'hE, 4'h4, -1, 0);   // SUBS -> Z
    chk("subs_flags", 32'(Flags), 32'h4);
    run_instr(2'd2, 6'b000000, 4'd0, 4'h0, 4'h0, -1, 0);   // BEQ taken
    run_instr(2'd0, 6'b000101, 4'd2, 4'hE, 4'h0, -1, 0);   // SUBS -> 0
    run_instr(2'd2, 6'b000000, 4'd0, 4'h0, 4'h0, -1, 0);   // BEQ not taken
    run_instr(2'd1, 6'b000001, 4'd3, 4'hE, 4'h0, -1, 0);   // LDR
    run_instr(2'd0, 6'b000101, 4'd2, 4'hE, 4'h4, -1, 0);   // SUBS -> Z
    run_instr(2'd1, 6'b000000, 4'd3, 4'h1, 4'h0, -1, 0);   // STRNE, Z=1
    run_instr(2'd0, 6'b001001, 4'd4, 4'hE, 4'hF, 2, 4);    // ADDS stalled in EXECR
    run_instr(2'd0, 6'b010101, 4'd5, 4'hE, 4'h9, -1, 0);   // CMP -> 1001

    // Reset while an LDR sits in MEMRD.
    Op = 2'd1; Funct = 6'b000001; Rd = 4'd6; Cond = 4'hE; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_memrd", 32'(state), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 0);
    chk("async_reset_flags", 32'(Flags), 0);
    @(posedge clk); #1;
    chk("held_reset_state", 32'(state), 0);
    chk("held_reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);
    reset = 1'b0;
    m_flags = 4'b0000;
    run_instr(2'd0, 6'b001000, 4'd15, 4'hE, 4'h0, -1, 0);  // ADD to R15

    for (int n = 0; n < 80; n++) begin
      logic [3:0] rd;
      int sa;
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(2'($urandom_range(0, 3)), 6'($urandom), rd, 4'($urandom), 4'($urandom),
                sa, int'($urandom_range(1, 3)));
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
